// File: rtl/bin2bcd_seq_pkg.sv
// rtl/bin2bcd_seq_pkg.sv - shared state encodings and constants for bin2bcd_seq
package bin2bcd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_e;

  localparam logic [3:0] BCD_MAX_NIBBLE = 4'h9;

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - double-dabble digit correction: add 3 when nibble >= 5
module bcd_digit_adj (
  input  logic [3:0] in_i,
  output logic [3:0] out_o
);

  assign out_o = (in_i >= 4'd5) ? (in_i + 4'd3) : in_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-add-3 binary to packed BCD converter
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [BIN_W-1:0]    bin,
  output logic [4*DIGITS-1:0] bcd,
  output logic                done,
  output logic                busy,
  output logic                ovf
);

  localparam int SCR_W = 4 * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam int LIM_W = $clog2(10 ** DIGITS);
  localparam int CMP_W = (BIN_W > LIM_W) ? BIN_W : LIM_W;
  localparam logic [CMP_W-1:0] BCD_LIMIT = CMP_W'(10 ** DIGITS - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   shift_q, shift_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [SCR_W-1:0]   scratch_q, scratch_d;
  logic [SCR_W-1:0]   bcd_q, bcd_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;
  logic [SCR_W-1:0]   adj;
  logic [CMP_W-1:0]   bin_ext;

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .in_i  (scratch_q[4*i +: 4]),
      .out_o (adj[4*i +: 4])
    );
  end

  assign bin_ext = CMP_W'(bin_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    bin_d     = bin_q;
    scratch_d = scratch_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          bin_d     = bin;
          shift_d   = bin;
          scratch_d = '0;
          cnt_d     = CNT_W'(BIN_W - 1);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // The bit leaving the top nibble is dropped; that only happens on overflow.
        scratch_d = SCR_W'({adj, shift_q[BIN_W-1]});
        shift_d   = shift_q << 1;
        cnt_d     = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (bin_ext > BCD_LIMIT) begin
          bcd_d = {DIGITS{BCD_MAX_NIBBLE}};
          ovf_d = 1'b1;
        end else begin
          bcd_d = scratch_q;
          ovf_d = 1'b0;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      bin_q     <= '0;
      scratch_q <= '0;
      bcd_q     <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      bin_q     <= bin_d;
      scratch_q <= scratch_d;
      bcd_q     <= bcd_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bcd  = bcd_q;
  assign done = done_q;
  assign ovf  = ovf_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - self-checking bench for bin2bcd_seq against a decimal model
module tb_bin2bcd_seq;

  localparam int BIN_W  = 14;
  localparam int DIGITS = 4;
  localparam int LAT    = BIN_W + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [BIN_W-1:0]  bin;
  logic [15:0]       bcd;
  logic              done;
  logic              busy;
  logic              ovf;

  int tests = 0;
  int fails = 0;
  logic [15:0] prev_bcd;
  logic        prev_ovf;

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .bcd   (bcd),
    .done  (done),
    .busy  (busy),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_bcd(input int v);
    logic [15:0] r;
    r = '0;
    if (v > 9999) return 16'h9999;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'((v / (10 ** d)) % 10);
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one conversion from IDLE and check latency, hold behaviour and result.
  task automatic run_conv(input int v);
    int  lat;
    bit  seen;
    logic [15:0] exp_b;
    logic        exp_o;
    exp_b = ref_bcd(v);
    exp_o = (v > 9999);
    bin   = BIN_W'(v);
    start = 1'b1;
    tick();
    start = 1'b0;
    bin   = BIN_W'($urandom);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("done_low_at_start", {31'd0, done}, 32'd0);
    lat  = 0;
    seen = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      tick();
      if (done) begin
        seen = 1'b1;
        lat  = c;
      end else begin
        check("busy_during", {31'd0, busy}, 32'd1);
        check("bcd_hold", {16'd0, bcd}, {16'd0, prev_bcd});
        check("ovf_hold", {31'd0, ovf}, {31'd0, prev_ovf});
      end
    end
    check("latency", lat, LAT);
    check("bcd_result", {16'd0, bcd}, {16'd0, exp_b});
    check("ovf_result", {31'd0, ovf}, {31'd0, exp_o});
    check("busy_at_done", {31'd0, busy}, 32'd0);
    prev_bcd = exp_b;
    prev_ovf = exp_o;
  endtask

  initial begin
    int dones;
    int first_done;
    int second_done;
    logic [15:0] b1;
    logic        o1;
    int bnd [11] = '{0, 1, 9, 10, 99, 100, 999, 1000, 9999, 10000, 16383};

    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    prev_bcd = '0;
    prev_ovf = 1'b0;
    #12;
    check("rst_bcd", {16'd0, bcd}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    rst_n = 1'b1;
    tick();
    tick();

    run_conv(0);
    tick();
    check("done_one_cycle", {31'd0, done}, 32'd0);
    run_conv(1234);

    // Back-to-back with start held: 9999 then 10000.
    bin   = BIN_W'(9999);
    start = 1'b1;
    tick();
    bin = BIN_W'(10000);
    first_done  = 0;
    second_done = 0;
    b1 = '0;
    o1 = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == LAT + 1) start = 1'b0;
      if (done) begin
        if (first_done == 0) begin
          first_done = c;
          b1 = bcd;
          o1 = ovf;
        end else if (second_done == 0) begin
          second_done = c;
        end
      end
      if (second_done != 0 && c == second_done) begin
        check("b2b_bcd2", {16'd0, bcd}, 32'h9999);
        check("b2b_ovf2", {31'd0, ovf}, 32'd1);
      end
    end
    check("b2b_first_at", first_done, LAT);
    check("b2b_bcd1", {16'd0, b1}, 32'h9999);
    check("b2b_ovf1", {31'd0, o1}, 32'd0);
    check("b2b_spacing", second_done - first_done, BIN_W + 2);
    prev_bcd = 16'h9999;
    prev_ovf = 1'b1;

    // Start while busy must be ignored.
    bin   = BIN_W'(42);
    start = 1'b1;
    tick();
    start = 1'b0;
    dones = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 5) begin
        start = 1'b1;
        bin   = BIN_W'(7777);
      end else begin
        start = 1'b0;
      end
      tick();
      if (done) begin
        dones++;
        check("ign_bcd", {16'd0, bcd}, 32'h0042);
        check("ign_ovf", {31'd0, ovf}, 32'd0);
      end
    end
    check("ign_done_count", dones, 1);
    prev_bcd = 16'h0042;
    prev_ovf = 1'b0;

    // Reset mid-conversion.
    bin   = BIN_W'(5678);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 8; c++) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_bcd", {16'd0, bcd}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    tick();
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (done) dones++;
    end
    check("mid_rst_no_done", dones, 0);
    check("mid_rst_bcd_hold", {16'd0, bcd}, 32'd0);
    prev_bcd = '0;
    prev_ovf = 1'b0;
    run_conv(5678);

    foreach (bnd[i]) run_conv(bnd[i]);
    for (int n = 0; n < 1500; n++) run_conv(int'($urandom_range(0, 16383)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
